// File: rtl/fetch_sched.sv
// fetch_sched: kernel-load sequencer and round-robin warp PC scheduler for the fetch stage
module fetch_sched #(
  parameter int I_DATA_WIDTH  = 32,
  parameter int I_ADDR_WIDTH  = 10,
  parameter int NUM_WARPS     = 4,
  parameter int WARP_ID_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [I_DATA_WIDTH-1:0]  load_data,
  input  logic                     load_last,
  input  logic                     run_start,
  input  logic [I_ADDR_WIDTH-1:0]  start_pc,
  input  logic [NUM_WARPS-1:0]     warp_stall,
  input  logic                     br_valid,
  input  logic [WARP_ID_WIDTH-1:0] br_warp,
  input  logic [I_ADDR_WIDTH-1:0]  br_target,
  input  logic                     exit_valid,
  input  logic [WARP_ID_WIDTH-1:0] exit_warp,
  input  logic [I_ADDR_WIDTH-1:0]  pc_p1,
  output logic [I_ADDR_WIDTH-1:0]  pc_r,
  output logic [I_ADDR_WIDTH-1:0]  pc_w,
  output logic                     we,
  output logic [I_DATA_WIDTH-1:0]  instr_i,
  output logic                     fetch_valid,
  output logic [WARP_ID_WIDTH-1:0] fetch_warp,
  output logic                     busy,
  output logic                     run_done,
  output logic                     load_ovf
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state, state_nx;
  logic [I_ADDR_WIDTH-1:0]  pc [NUM_WARPS];
  logic [I_ADDR_WIDTH-1:0]  load_cnt, pc_last;
  logic [NUM_WARPS-1:0]     active, active_nx, exit_mask, elig;
  logic [WARP_ID_WIDTH-1:0] rr, gnt;
  logic                     found, launch;
  // eligibility and round-robin pick: lowest offset from rr wins
  always_comb begin
    exit_mask = exit_valid ? NUM_WARPS'(1) << exit_warp : '0;
    elig = (state == RUN) ? active & ~warp_stall & ~exit_mask : '0;
    active_nx = active & ~exit_mask;
    launch = (state == IDLE) & ~load_start & run_start;
    found = 1'b0;
    gnt = rr;
    for (int i = NUM_WARPS - 1; i >= 0; i--)
      if (elig[rr + WARP_ID_WIDTH'(i)]) begin
        found = 1'b1;
        gnt = rr + WARP_ID_WIDTH'(i);
      end
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next state: load_start beats run_start in IDLE, RUN ends when no warp remains active
  always_comb
    state_nx = (state == IDLE) ? (load_start ? LOAD : run_start ? RUN : IDLE)
             : (state == LOAD) ? ((load_valid & load_last) ? IDLE : LOAD)
             : (state == RUN)  ? ((active_nx == '0) ? IDLE : RUN)
             : IDLE;
  // outputs: load port is combinational so the write hits the same cycle's BRAM edge
  always_comb begin
    we = (state == LOAD) & load_valid;
    pc_w = (state == LOAD) ? load_cnt : '0;
    instr_i = (state == LOAD) ? load_data : '0;
    pc_r = found ? pc[gnt] : pc_last;
    busy = state != IDLE;
  end
  // control registers: active mask, rr pointer, load counter, fetch tags
  always_ff @(posedge clk)
    if (rst) begin
      active <= '0;
      rr <= '0;
      load_cnt <= '0;
      load_ovf <= 1'b0;
      pc_last <= '0;
      fetch_valid <= 1'b0;
      fetch_warp <= '0;
      run_done <= 1'b0;
    end else begin
      fetch_valid <= found;
      run_done <= (state == RUN) & (active_nx == '0);
      if (found) begin
        fetch_warp <= gnt;
        rr <= gnt + 1'b1;
        pc_last <= pc[gnt];
      end
      if ((state == IDLE) & load_start) begin
        load_cnt <= '0;
        load_ovf <= 1'b0;
      end
      if (launch) begin
        active <= '1;
        rr <= '0;
      end
      if ((state == LOAD) & load_valid) begin
        load_cnt <= load_cnt + 1'b1;
        if ((&load_cnt) & ~load_last) load_ovf <= 1'b1;
      end
      if (state == RUN) active <= active_nx;
    end
  // per-warp PC: branch redirect beats the granted PC+1 write-back
  always_ff @(posedge clk)
    for (int w = 0; w < NUM_WARPS; w++)
      if (rst) pc[w] <= '0;
      else if (launch) pc[w] <= start_pc;
      else if ((state == RUN) & br_valid & (br_warp == WARP_ID_WIDTH'(w))) pc[w] <= br_target;
      else if (found & (gnt == WARP_ID_WIDTH'(w))) pc[w] <= pc_p1;
endmodule

// File: tb/tb_fetch_sched.sv
// tb_fetch_sched: directed and randomized checks of fetch_sched against a cycle-level behavioural model
module tb_fetch_sched;
  localparam int DW = 32, AW = 10, NW = 4, WW = 2, SAW = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic load_start = 0, load_valid = 0, load_last = 0, run_start = 0;
  logic [DW-1:0] load_data = '0;
  logic [AW-1:0] start_pc = '0, br_target = '0, pc_p1, pc_r, pc_w;
  logic [NW-1:0] warp_stall = '0;
  logic br_valid = 0, exit_valid = 0;
  logic [WW-1:0] br_warp = '0, exit_warp = '0, fetch_warp;
  logic we, fetch_valid, busy, run_done, load_ovf;
  logic [DW-1:0] instr_i;
  logic [SAW-1:0] s_pc_r, s_pc_w, s_pc_p1;
  logic [DW-1:0] s_instr;
  logic [WW-1:0] s_fw;
  logic s_we, s_fv, s_busy, s_done, s_ovf;
  int vectors = 0, miscompares = 0;

  fetch_sched dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .run_start(run_start), .start_pc(start_pc), .warp_stall(warp_stall),
    .br_valid(br_valid), .br_warp(br_warp), .br_target(br_target), .exit_valid(exit_valid),
    .exit_warp(exit_warp), .pc_p1(pc_p1), .pc_r(pc_r), .pc_w(pc_w), .we(we), .instr_i(instr_i),
    .fetch_valid(fetch_valid), .fetch_warp(fetch_warp), .busy(busy), .run_done(run_done), .load_ovf(load_ovf));

  fetch_sched #(.I_ADDR_WIDTH(SAW)) dut_s (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .run_start(1'b0), .start_pc(3'd0), .warp_stall(4'd0),
    .br_valid(1'b0), .br_warp(2'd0), .br_target(3'd0), .exit_valid(1'b0),
    .exit_warp(2'd0), .pc_p1(s_pc_p1), .pc_r(s_pc_r), .pc_w(s_pc_w), .we(s_we), .instr_i(s_instr),
    .fetch_valid(s_fv), .fetch_warp(s_fw), .busy(s_busy), .run_done(s_done), .load_ovf(s_ovf));

  always #5 clk = ~clk;
  assign pc_p1 = pc_r + 1'b1;
  assign s_pc_p1 = s_pc_r + 1'b1;

  // behavioural model: 0 idle, 1 load, 2 run
  int m_state, m_rr, m_cnt, m_fw, m_pclast;
  int m_pc [NW];
  bit m_act [NW];
  bit m_ovf, m_fv, m_done, e_found;
  int e_g, e_pcr;

  function automatic void model_grant();
    e_found = 0;
    e_g = 0;
    if (m_state == 2)
      for (int k = 0; k < NW; k++) begin
        int w = (m_rr + k) % NW;
        if (!e_found && m_act[w] && !warp_stall[w] && !(exit_valid && exit_warp == w)) begin
          e_found = 1;
          e_g = w;
        end
      end
    e_pcr = e_found ? m_pc[e_g] : m_pclast;
  endfunction

  task automatic model_tick();
    bit any;
    model_grant();
    if (rst) begin
      m_state = 0; m_rr = 0; m_cnt = 0; m_fw = 0; m_pclast = 0;
      m_ovf = 0; m_fv = 0; m_done = 0;
      for (int w = 0; w < NW; w++) begin m_pc[w] = 0; m_act[w] = 0; end
    end else begin
      m_fv = e_found;
      if (e_found) m_fw = e_g;
      m_done = 0;
      case (m_state)
        0: if (load_start) begin
             m_state = 1; m_cnt = 0; m_ovf = 0;
           end else if (run_start) begin
             m_state = 2; m_rr = 0;
             for (int w = 0; w < NW; w++) begin m_pc[w] = int'(start_pc); m_act[w] = 1; end
           end
        1: if (load_valid) begin
             if (m_cnt == (1 << AW) - 1 && !load_last) m_ovf = 1;
             m_cnt = (m_cnt + 1) % (1 << AW);
             if (load_last) m_state = 0;
           end
        default: begin
          if (e_found) begin m_pclast = m_pc[e_g]; m_rr = (e_g + 1) % NW; end
          for (int w = 0; w < NW; w++)
            if (br_valid && br_warp == w) m_pc[w] = int'(br_target);
            else if (e_found && e_g == w) m_pc[w] = (m_pc[w] + 1) % (1 << AW);
          if (exit_valid) m_act[exit_warp] = 0;
          any = 0;
          for (int w = 0; w < NW; w++) any |= m_act[w];
          if (!any) begin m_state = 0; m_done = 1; end
        end
      endcase
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic quiet();
    load_start = 0; load_valid = 0; load_last = 0; run_start = 0;
    warp_stall = '0; br_valid = 0; exit_valid = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1;
    clk_step();
    clk_step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #3;
    vectors += 8;
    if (busy !== 0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (fetch_valid !== 0) begin miscompares++; $display("FAIL reset_fv got %b exp 0", fetch_valid); end
    if (we !== 0) begin miscompares++; $display("FAIL reset_we got %b exp 0", we); end
    if (pc_r !== 0) begin miscompares++; $display("FAIL reset_pc_r got %h exp 0", pc_r); end
    if (pc_w !== 0 || instr_i !== 0) begin miscompares++; $display("FAIL reset_pc_w/instr got %h/%h exp 0/0", pc_w, instr_i); end
    if (run_done !== 0 || fetch_warp !== 0) begin miscompares++; $display("FAIL reset_done/fw got %b/%h exp 0/0", run_done, fetch_warp); end
    if (load_ovf !== 0) begin miscompares++; $display("FAIL reset_ovf got %b exp 0", load_ovf); end
    if (s_ovf !== 0 || s_busy !== 0 || s_we !== 0) begin miscompares++; $display("FAIL reset_small got ovf=%b busy=%b we=%b exp 0", s_ovf, s_busy, s_we); end
    clk_step();
  endtask

  task automatic test_load();
    do_reset();
    load_start = 1;
    clk_step();
    load_start = 0;
    load_last = 1;
    #3;
    vectors += 2;
    if (we !== 0) begin miscompares++; $display("FAIL load_last_only_we got %b exp 0", we); end
    clk_step();
    if (busy !== 1) begin miscompares++; $display("FAIL load_last_only_busy got %b exp 1", busy); end
    for (int i = 0; i < 5; i++) begin
      load_valid = 1;
      load_last = (i == 4);
      load_data = DW'(32'hA0 + i);
      #3;
      vectors += 3;
      if (we !== 1) begin miscompares++; $display("FAIL load_we[%0d] got %b exp 1", i, we); end
      if (pc_w !== AW'(i)) begin miscompares++; $display("FAIL load_pc_w[%0d] got %h exp %h", i, pc_w, i); end
      if (instr_i !== DW'(32'hA0 + i)) begin miscompares++; $display("FAIL load_instr[%0d] got %h exp %h", i, instr_i, 32'hA0 + i); end
      clk_step();
    end
    quiet();
    #3;
    vectors += 3;
    if (busy !== 0) begin miscompares++; $display("FAIL load_end_busy got %b exp 0", busy); end
    if (load_ovf !== 0) begin miscompares++; $display("FAIL load_end_ovf got %b exp 0", load_ovf); end
    if (we !== 0) begin miscompares++; $display("FAIL load_end_we got %b exp 0", we); end
    clk_step();
  endtask

  task automatic test_overflow();
    do_reset();
    load_start = 1;
    clk_step();
    load_start = 0;
    for (int i = 0; i < 9; i++) begin
      load_valid = 1;
      load_last = (i == 8);
      load_data = DW'(i);
      #3;
      vectors += 2;
      if (s_we !== 1) begin miscompares++; $display("FAIL ovf_we[%0d] got %b exp 1", i, s_we); end
      if (s_pc_w !== SAW'(i % 8)) begin miscompares++; $display("FAIL ovf_pc_w[%0d] got %h exp %h", i, s_pc_w, i % 8); end
      clk_step();
      vectors++;
      if (s_ovf !== (i >= 7)) begin miscompares++; $display("FAIL ovf_flag[%0d] got %b exp %b", i, s_ovf, i >= 7); end
    end
    quiet();
    vectors++;
    if (s_busy !== 0) begin miscompares++; $display("FAIL ovf_busy got %b exp 0", s_busy); end
    load_start = 1;
    clk_step();
    vectors++;
    if (s_ovf !== 0) begin miscompares++; $display("FAIL ovf_clear got %b exp 0", s_ovf); end
    load_start = 0;
    load_valid = 1;
    load_last = 1;
    clk_step();
    quiet();
  endtask

  task automatic test_round_robin();
    do_reset();
    run_start = 1;
    start_pc = AW'(16'h10);
    clk_step();
    run_start = 0;
    for (int k = 0; k < 8; k++) begin
      #3;
      vectors++;
      if (pc_r !== AW'(k < 4 ? 16'h10 : 16'h11)) begin miscompares++; $display("FAIL rr_pc_r[%0d] got %h exp %h", k, pc_r, k < 4 ? 16'h10 : 16'h11); end
      clk_step();
      vectors += 2;
      if (fetch_valid !== 1) begin miscompares++; $display("FAIL rr_fv[%0d] got %b exp 1", k, fetch_valid); end
      if (fetch_warp !== WW'(k % 4)) begin miscompares++; $display("FAIL rr_fw[%0d] got %0d exp %0d", k, fetch_warp, k % 4); end
    end
  endtask

  task automatic test_stall_branch();
    int exp_w [5] = '{0, 2, 3, 0, 2};
    int exp_pc [5] = '{16'h10, 16'h10, 16'h10, 16'h11, 16'h40};
    do_reset();
    run_start = 1;
    start_pc = AW'(16'h10);
    clk_step();
    run_start = 0;
    warp_stall = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      br_valid = (k == 1);
      br_warp = 2'd2;
      br_target = AW'(16'h40);
      #3;
      vectors++;
      if (pc_r !== AW'(exp_pc[k])) begin miscompares++; $display("FAIL sb_pc_r[%0d] got %h exp %h", k, pc_r, exp_pc[k]); end
      clk_step();
      vectors++;
      if (fetch_valid !== 1 || fetch_warp !== WW'(exp_w[k])) begin miscompares++; $display("FAIL sb_fw[%0d] got %b/%0d exp 1/%0d", k, fetch_valid, fetch_warp, exp_w[k]); end
    end
    quiet();
  endtask

  task automatic test_exit_done();
    int ex [5] = '{0, 1, 2, -1, 3};
    bit exp_fv [6] = '{1, 1, 1, 1, 0, 0};
    int exp_fw [6] = '{1, 2, 3, 3, 3, 3};
    bit exp_done [6] = '{0, 0, 0, 0, 1, 0};
    bit exp_busy [6] = '{1, 1, 1, 1, 0, 0};
    int exp_pc [5] = '{16'h20, 16'h20, 16'h20, 16'h21, 16'h21};
    do_reset();
    run_start = 1;
    start_pc = AW'(16'h20);
    clk_step();
    run_start = 0;
    for (int k = 0; k < 6; k++) begin
      exit_valid = (k < 5) && (ex[k] >= 0);
      exit_warp = WW'(k < 5 && ex[k] >= 0 ? ex[k] : 0);
      #3;
      if (k < 5) begin
        vectors++;
        if (pc_r !== AW'(exp_pc[k])) begin miscompares++; $display("FAIL ed_pc_r[%0d] got %h exp %h", k, pc_r, exp_pc[k]); end
      end
      clk_step();
      vectors += 3;
      if (fetch_valid !== exp_fv[k] || (exp_fv[k] && fetch_warp !== WW'(exp_fw[k]))) begin miscompares++; $display("FAIL ed_fetch[%0d] got %b/%0d exp %b/%0d", k, fetch_valid, fetch_warp, exp_fv[k], exp_fw[k]); end
      if (run_done !== exp_done[k]) begin miscompares++; $display("FAIL ed_done[%0d] got %b exp %b", k, run_done, exp_done[k]); end
      if (busy !== exp_busy[k]) begin miscompares++; $display("FAIL ed_busy[%0d] got %b exp %b", k, busy, exp_busy[k]); end
    end
    quiet();
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    run_start = 1;
    start_pc = AW'(16'h155);
    clk_step();
    run_start = 0;
    clk_step();
    clk_step();
    rst = 1;
    clk_step();
    rst = 0;
    vectors += 3;
    if (fetch_valid !== 0) begin miscompares++; $display("FAIL rmr_fv got %b exp 0", fetch_valid); end
    if (busy !== 0) begin miscompares++; $display("FAIL rmr_busy got %b exp 0", busy); end
    if (pc_r !== 0) begin miscompares++; $display("FAIL rmr_pc_r got %h exp 0", pc_r); end
    run_start = 1;
    start_pc = '0;
    clk_step();
    run_start = 0;
    for (int k = 0; k < 4; k++) begin
      #3;
      vectors++;
      if (pc_r !== 0) begin miscompares++; $display("FAIL rmr_pc_w%0d got %h exp 0", k, pc_r); end
      clk_step();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      load_start = ($urandom_range(0, 7) == 0);
      run_start = $urandom_range(0, 1) != 0;
      start_pc = AW'($urandom);
      load_valid = $urandom_range(0, 2) != 0;
      load_last = $urandom_range(0, 5) == 0;
      load_data = $urandom;
      warp_stall = NW'($urandom) & NW'($urandom);
      br_valid = $urandom_range(0, 3) == 0;
      br_warp = WW'($urandom);
      br_target = AW'($urandom);
      exit_valid = $urandom_range(0, 11) == 0;
      exit_warp = WW'($urandom);
      model_grant();
      #3;
      vectors += 4;
      if (pc_r !== AW'(e_pcr)) begin miscompares++; $display("FAIL rnd_pc_r[%0d] got %h exp %h", c, pc_r, e_pcr); end
      if (we !== (m_state == 1 && load_valid)) begin miscompares++; $display("FAIL rnd_we[%0d] got %b exp %b", c, we, m_state == 1 && load_valid); end
      if (pc_w !== AW'(m_state == 1 ? m_cnt : 0)) begin miscompares++; $display("FAIL rnd_pc_w[%0d] got %h exp %h", c, pc_w, m_state == 1 ? m_cnt : 0); end
      if (instr_i !== (m_state == 1 ? load_data : '0)) begin miscompares++; $display("FAIL rnd_instr[%0d] got %h exp %h", c, instr_i, m_state == 1 ? load_data : '0); end
      clk_step();
      vectors += 5;
      if (fetch_valid !== m_fv) begin miscompares++; $display("FAIL rnd_fv[%0d] got %b exp %b", c, fetch_valid, m_fv); end
      if (fetch_warp !== WW'(m_fw)) begin miscompares++; $display("FAIL rnd_fw[%0d] got %0d exp %0d", c, fetch_warp, m_fw); end
      if (run_done !== m_done) begin miscompares++; $display("FAIL rnd_done[%0d] got %b exp %b", c, run_done, m_done); end
      if (busy !== (m_state != 0)) begin miscompares++; $display("FAIL rnd_busy[%0d] got %b exp %b", c, busy, m_state != 0); end
      if (load_ovf !== m_ovf) begin miscompares++; $display("FAIL rnd_ovf[%0d] got %b exp %b", c, load_ovf, m_ovf); end
    end
    quiet();
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_overflow();
    test_round_robin();
    test_stall_branch();
    test_exit_done();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_sched.md
Name: fetch_sched

Overview:
- Sequences the instruction-fetch stage of one multiprocessor.
- Two jobs, one at a time:
  - LOAD: streams a kernel image into the instruction cache through the fetch stage's write port.
  - RUN: keeps one PC per warp and, each cycle, grants one eligible warp round-robin. It drives that warp's PC to the fetch read port and writes back the fetch stage's PC+1 (or a branch target).
- Sits between the MP control/host interface and the fetch stage. Decode sees fetch_valid/fetch_warp aligned with the fetched instruction.

Parameters:
- I_DATA_WIDTH, 32, instruction width
- I_ADDR_WIDTH, 10, instruction cache address bits
- NUM_WARPS, 4, warps per MP (power of two, ≥2)
- WARP_ID_WIDTH, 2, log2(NUM_WARPS)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- load_start  in  1  begin kernel load (honoured in IDLE only)
- load_valid  in  1  load_data valid this cycle
- load_data  in  I_DATA_WIDTH  instruction to store
- load_last  in  1  qualifies load_valid; final word of the image
- run_start  in  1  launch all warps (honoured in IDLE only)
- start_pc  in  I_ADDR_WIDTH  entry PC for all warps
- warp_stall  in  NUM_WARPS  bit w=1: warp w not eligible this cycle
- br_valid  in  1  branch redirect
- br_warp  in  WARP_ID_WIDTH  warp being redirected
- br_target  in  I_ADDR_WIDTH  new PC
- exit_valid  in  1  warp finished
- exit_warp  in  WARP_ID_WIDTH  finishing warp
- pc_p1  in  I_ADDR_WIDTH  PC+1 from fetch stage (combinational from pc_r)
- pc_r  out  I_ADDR_WIDTH  fetch read address
- pc_w  out  I_ADDR_WIDTH  fetch write address
- we  out  1  fetch write enable
- instr_i  out  I_DATA_WIDTH  instruction to write
- fetch_valid  out  1  instr_f valid this cycle
- fetch_warp  out  WARP_ID_WIDTH  owner of instr_f
- busy  out  1  state != IDLE
- run_done  out  1  one-cycle pulse: last warp exited
- load_ovf  out  1  sticky: load address wrapped

Behaviour:
- Reset values: all outputs 0; state IDLE; all PCs 0; active mask 0; RR pointer 0; load counter 0. Reset mid-LOAD or mid-RUN aborts immediately, with no further we or fetch_valid.
- States: IDLE, LOAD, RUN.
- IDLE:
  - load_start → LOAD; clears load counter and load_ovf.
  - Else run_start → RUN; every PC = start_pc, active mask all ones, RR pointer 0.
  - If both are asserted, load_start wins.
  - Either input is ignored outside IDLE.
- LOAD:
  - we = load_valid, pc_w = load counter, instr_i = load_data. All three are combinational from inputs and the counter, so the write lands in the same cycle's BRAM edge.
  - Counter increments on each load_valid and wraps modulo 2^I_ADDR_WIDTH. A write at address 2^I_ADDR_WIDTH−1 that is not load_last sets load_ovf.
  - load_valid & load_last → IDLE next cycle.
  - load_last without load_valid is ignored.
  - we is 0 in all other states.
- RUN grant:
  - Eligible(w) = active[w] & ~warp_stall[w] & ~(exit_valid & exit_warp==w).
  - Grant goes to the first eligible warp starting at RR pointer, then upward with wrap.
  - On a grant, RR pointer ← granted+1 (mod NUM_WARPS).
  - With no eligible warp, there is no grant and the pointer is unchanged.
- RUN outputs:
  - pc_r = PC[granted] combinationally. With no grant, pc_r holds its last value.
  - fetch_valid/fetch_warp are registered: asserted the cycle after the grant, aligned with the BRAM's 1-cycle read latency.
- PC update priority, per warp, per cycle:
  1. br_valid for that warp → PC ← br_target, regardless of grant.
  2. Else granted → PC ← pc_p1 (wraps naturally at 2^I_ADDR_WIDTH).
  3. Else hold.
- Exit: exit_valid clears active[exit_warp] and suppresses that warp's grant the same cycle. Exit of an already-inactive warp is a no-op.
- Simultaneous branch and exit on the same warp: the warp goes inactive; the PC update is don't-care.
- Completion: when the active mask becomes all zero, run_done pulses one cycle and state → IDLE. The fetch_valid from the final grant still appears one cycle after that grant.
- br/exit inputs are ignored outside RUN.

Test Plan:
- Load: load_start, then 5 load_valid words 0xA0..0xA4 with load_last on the 5th → we high 5 cycles, pc_w 0..4, then IDLE, busy=0, load_ovf=0.
- Overflow: I_ADDR_WIDTH=3, load 9 words, last on 9th → pc_w 0..7 then 0; load_ovf=1 after the 8th write; the next load_start clears it.
- Round-robin: run_start, start_pc=0x10, no stalls → grants w0,w1,w2,w3,w0…; pc_r 0x10 ×4 then 0x11; fetch_valid/fetch_warp follow one cycle later.
- Stall/branch: warp_stall=0b0010 → w1 skipped. br_valid on w2 target 0x40 in the same cycle w2 is granted → w2's next pc_r = 0x40, not 0x11.
- Exit/done: exit w0,w1,w2 in successive cycles, then w3 two cycles later → no grants to exited warps; run_done pulses exactly once after w3's exit; state IDLE.
- Reset mid-RUN: assert rst during grants → next cycle fetch_valid=0, busy=0, and all PCs read back as 0 on the next run_start with start_pc=0.
